// File: rtl/axilm_cmd_master.sv
// axilm_cmd_master: single-outstanding AXI4-Lite master fed by a valid/ready command port.
// Every output comes straight from a flop. DATA_WIDTH must be 32 or 64.
module axilm_cmd_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 256,
   parameter logic [3:0]  AXCACHE    = 4'b0011
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic                    CMD_WRITE,
   input  logic [ADDR_WIDTH-1:0]   CMD_ADDR,
   input  logic [DATA_WIDTH-1:0]   CMD_WDATA,
   input  logic [DATA_WIDTH/8-1:0] CMD_WSTRB,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic                    RSP_WRITE,
   output logic [DATA_WIDTH-1:0]   RSP_RDATA,
   output logic [1:0]              RSP_RESP,
   output logic                    RSP_TIMEOUT,
   output logic [ADDR_WIDTH-1:0]   AXI_AWADDR,
   output logic [3:0]              AXI_AWCACHE,
   output logic [2:0]              AXI_AWPROT,
   output logic                    AXI_AWVALID,
   input  logic                    AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]   AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0] AXI_WSTRB,
   output logic                    AXI_WVALID,
   input  logic                    AXI_WREADY,
   input  logic                    AXI_BVALID,
   input  logic [1:0]              AXI_BRESP,
   output logic                    AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]   AXI_ARADDR,
   output logic [3:0]              AXI_ARCACHE,
   output logic [2:0]              AXI_ARPROT,
   output logic                    AXI_ARVALID,
   input  logic                    AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]   AXI_RDATA,
   input  logic [1:0]              AXI_RRESP,
   input  logic                    AXI_RVALID,
   output logic                    AXI_RREADY
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   // One spare bit is kept when the timeout is disabled so the counter never has zero width.
   localparam int unsigned CNT_WIDTH  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   // Abort fires on the edge that ends the TIMEOUT-th wait cycle.
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle, StWrReq, StWrResp, StRdReq, StRdData, StResp
   } state_e;

   state_e                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    bready_q, bready_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic                    rsp_write_q, rsp_write_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    rsp_timeout_q, rsp_timeout_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic [3:0]              awcache_q, awcache_d;
   logic [3:0]              arcache_q, arcache_d;

   logic accept, aw_pend, w_pend, wait_st, timeout_hit, abort;

   assign accept      = (state_q == StIdle) && cmd_ready_q && CMD_VALID;
   // A channel stays pending until VALID & READY meet at an edge.
   assign aw_pend     = awvalid_q && !AXI_AWREADY;
   assign w_pend      = wvalid_q && !AXI_WREADY;
   assign wait_st     = (state_q == StWrReq) || (state_q == StWrResp) ||
                        (state_q == StRdReq) || (state_q == StRdData);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   // Next-state and next-output logic; all outputs are computed one cycle ahead and registered.
   always_comb begin
      state_d       = state_q;
      abort         = 1'b0;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      rsp_write_d   = rsp_write_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               rsp_write_d   = CMD_WRITE;
               rsp_rdata_d   = '0;
               rsp_resp_d    = 2'b00;
               rsp_timeout_d = 1'b0;
               if (CMD_WRITE) begin
                  state_d   = StWrReq;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d = StRdReq;
               end
            end
         end
         StWrReq: begin
            if (!aw_pend && !w_pend) begin
               state_d = StWrResp;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end else begin
               awvalid_d = aw_pend;
               wvalid_d  = w_pend;
            end
         end
         StWrResp: begin
            if (AXI_BVALID) begin
               rsp_resp_d = AXI_BRESP;
               state_d    = StResp;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         StRdReq: begin
            if (AXI_ARREADY) begin
               state_d = StRdData;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         StRdData: begin
            if (AXI_RVALID) begin
               rsp_rdata_d = AXI_RDATA;
               rsp_resp_d  = AXI_RRESP;
               state_d     = StResp;
            end else if (timeout_hit) begin
               abort = 1'b1;
            end
         end
         StResp: begin
            if (RSP_READY) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Debug recovery: drop the bus mid-transaction and report a SLVERR-style timeout.
      if (abort) begin
         state_d       = StResp;
         rsp_timeout_d = 1'b1;
         rsp_resp_d    = 2'b10;
         rsp_rdata_d   = '0;
      end

      cmd_ready_d = (state_d == StIdle);
      bready_d    = (state_d == StWrResp);
      arvalid_d   = (state_d == StRdReq);
      rready_d    = (state_d == StRdData);
      rsp_valid_d = (state_d == StResp);

      // Payloads are zero unless their VALID is high; reload from the command only on accept.
      awaddr_d  = !awvalid_d ? '0 : (accept ? CMD_ADDR : awaddr_q);
      wdata_d   = !wvalid_d ? '0 : (accept ? CMD_WDATA : wdata_q);
      wstrb_d   = !wvalid_d ? '0 : (accept ? CMD_WSTRB : wstrb_q);
      araddr_d  = !arvalid_d ? '0 : (accept ? CMD_ADDR : araddr_q);
      awcache_d = awvalid_d ? AXCACHE : 4'b0000;
      arcache_d = arvalid_d ? AXCACHE : 4'b0000;

      cnt_d = (wait_st && (state_d == state_q)) ? cnt_q + CNT_WIDTH'(1) : '0;
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_write_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
         awaddr_q      <= '0;
         araddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         awcache_q     <= 4'b0000;
         arcache_q     <= 4'b0000;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_write_q   <= rsp_write_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
         awaddr_q      <= awaddr_d;
         araddr_q      <= araddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         awcache_q     <= awcache_d;
         arcache_q     <= arcache_d;
      end
   end

   assign CMD_READY   = cmd_ready_q;
   assign RSP_VALID   = rsp_valid_q;
   assign RSP_WRITE   = rsp_write_q;
   assign RSP_RDATA   = rsp_rdata_q;
   assign RSP_RESP    = rsp_resp_q;
   assign RSP_TIMEOUT = rsp_timeout_q;
   assign AXI_AWADDR  = awaddr_q;
   assign AXI_AWCACHE = awcache_q;
   assign AXI_AWPROT  = 3'b000;
   assign AXI_AWVALID = awvalid_q;
   assign AXI_WDATA   = wdata_q;
   assign AXI_WSTRB   = wstrb_q;
   assign AXI_WVALID  = wvalid_q;
   assign AXI_BREADY  = bready_q;
   assign AXI_ARADDR  = araddr_q;
   assign AXI_ARCACHE = arcache_q;
   assign AXI_ARPROT  = 3'b000;
   assign AXI_ARVALID = arvalid_q;
   assign AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axilm_cmd_master.sv
// Directed bench for axilm_cmd_master: 32-bit instance with TIMEOUT = 16 plus a 64-bit instance.
module tb_axilm_cmd_master;

   logic ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   logic ARESET;

   // 32-bit instance signals
   logic        CMD_VALID, CMD_READY, CMD_WRITE;
   logic [31:0] CMD_ADDR, CMD_WDATA;
   logic [3:0]  CMD_WSTRB;
   logic        RSP_VALID, RSP_READY, RSP_WRITE, RSP_TIMEOUT;
   logic [31:0] RSP_RDATA;
   logic [1:0]  RSP_RESP;
   logic [31:0] AXI_AWADDR, AXI_ARADDR, AXI_WDATA, AXI_RDATA;
   logic [3:0]  AXI_AWCACHE, AXI_ARCACHE, AXI_WSTRB;
   logic [2:0]  AXI_AWPROT, AXI_ARPROT;
   logic        AXI_AWVALID, AXI_AWREADY, AXI_WVALID, AXI_WREADY;
   logic        AXI_BVALID, AXI_BREADY, AXI_ARVALID, AXI_ARREADY, AXI_RVALID, AXI_RREADY;
   logic [1:0]  AXI_BRESP, AXI_RRESP;

   // 64-bit instance signals
   logic        w64_cmd_valid, w64_cmd_ready, w64_cmd_write;
   logic [31:0] w64_cmd_addr;
   logic [63:0] w64_cmd_wdata;
   logic [7:0]  w64_cmd_wstrb;
   logic        w64_rsp_valid, w64_rsp_ready, w64_rsp_write, w64_rsp_timeout;
   logic [63:0] w64_rsp_rdata;
   logic [1:0]  w64_rsp_resp;
   logic [31:0] w64_awaddr, w64_araddr;
   logic [63:0] w64_wdata, w64_rdata;
   logic [7:0]  w64_wstrb;
   logic [3:0]  w64_awcache, w64_arcache;
   logic [2:0]  w64_awprot, w64_arprot;
   logic        w64_awvalid, w64_awready, w64_wvalid, w64_wready;
   logic        w64_bvalid, w64_bready, w64_arvalid, w64_arready, w64_rvalid, w64_rready;
   logic [1:0]  w64_bresp, w64_rresp;

   int checks = 0;
   int errors = 0;

   axilm_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16), .AXCACHE(4'b0011)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_WRITE(RSP_WRITE),
      .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .RSP_TIMEOUT(RSP_TIMEOUT),
      .AXI_AWADDR(AXI_AWADDR), .AXI_AWCACHE(AXI_AWCACHE), .AXI_AWPROT(AXI_AWPROT),
      .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
      .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID),
      .AXI_WREADY(AXI_WREADY), .AXI_BVALID(AXI_BVALID), .AXI_BRESP(AXI_BRESP),
      .AXI_BREADY(AXI_BREADY), .AXI_ARADDR(AXI_ARADDR), .AXI_ARCACHE(AXI_ARCACHE),
      .AXI_ARPROT(AXI_ARPROT), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
      .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID),
      .AXI_RREADY(AXI_RREADY)
   );

   axilm_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(256), .AXCACHE(4'b0011)) dut64 (
      .ACLK(ACLK), .ARESET(ARESET),
      .CMD_VALID(w64_cmd_valid), .CMD_READY(w64_cmd_ready), .CMD_WRITE(w64_cmd_write),
      .CMD_ADDR(w64_cmd_addr), .CMD_WDATA(w64_cmd_wdata), .CMD_WSTRB(w64_cmd_wstrb),
      .RSP_VALID(w64_rsp_valid), .RSP_READY(w64_rsp_ready), .RSP_WRITE(w64_rsp_write),
      .RSP_RDATA(w64_rsp_rdata), .RSP_RESP(w64_rsp_resp), .RSP_TIMEOUT(w64_rsp_timeout),
      .AXI_AWADDR(w64_awaddr), .AXI_AWCACHE(w64_awcache), .AXI_AWPROT(w64_awprot),
      .AXI_AWVALID(w64_awvalid), .AXI_AWREADY(w64_awready),
      .AXI_WDATA(w64_wdata), .AXI_WSTRB(w64_wstrb), .AXI_WVALID(w64_wvalid),
      .AXI_WREADY(w64_wready), .AXI_BVALID(w64_bvalid), .AXI_BRESP(w64_bresp),
      .AXI_BREADY(w64_bready), .AXI_ARADDR(w64_araddr), .AXI_ARCACHE(w64_arcache),
      .AXI_ARPROT(w64_arprot), .AXI_ARVALID(w64_arvalid), .AXI_ARREADY(w64_arready),
      .AXI_RDATA(w64_rdata), .AXI_RRESP(w64_rresp), .AXI_RVALID(w64_rvalid),
      .AXI_RREADY(w64_rready)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic send(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
      CMD_VALID = 1'b1;
      CMD_WRITE = wr;
      CMD_ADDR  = addr;
      CMD_WDATA = data;
      CMD_WSTRB = strb;
      tick();
      CMD_VALID = 1'b0;
      CMD_WDATA = 32'h0;
      CMD_WSTRB = 4'h0;
   endtask

   initial begin
      int n;
      ARESET = 1'b1;
      CMD_VALID = 1'b0; CMD_WRITE = 1'b0; CMD_ADDR = 32'h0; CMD_WDATA = 32'h0; CMD_WSTRB = 4'h0;
      RSP_READY = 1'b1;
      AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0; AXI_BVALID = 1'b0; AXI_BRESP = 2'b00;
      AXI_ARREADY = 1'b0; AXI_RVALID = 1'b0; AXI_RDATA = 32'h0; AXI_RRESP = 2'b00;
      w64_cmd_valid = 1'b0; w64_cmd_write = 1'b0; w64_cmd_addr = 32'h0;
      w64_cmd_wdata = 64'h0; w64_cmd_wstrb = 8'h0; w64_rsp_ready = 1'b1;
      w64_awready = 1'b1; w64_wready = 1'b1; w64_bvalid = 1'b0; w64_bresp = 2'b00;
      w64_arready = 1'b0; w64_rvalid = 1'b0; w64_rdata = 64'h0; w64_rresp = 2'b00;

      // Reset state
      repeat (3) tick();
      check("rst_cmd_ready", CMD_READY, 1'b0);
      check("rst_awvalid", AXI_AWVALID, 1'b0);
      check("rst_rsp_valid", RSP_VALID, 1'b0);
      check("rst_awprot", AXI_AWPROT, 3'b000);
      ARESET = 1'b0;
      tick();
      check("rel_cmd_ready", CMD_READY, 1'b1);

      // Write, always-ready slave
      AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
      send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
      check("wr_awvalid_c1", AXI_AWVALID, 1'b1);
      check("wr_wvalid_c1", AXI_WVALID, 1'b1);
      check("wr_awaddr", AXI_AWADDR, 32'h10);
      check("wr_wdata", AXI_WDATA, 32'hDEAD_BEEF);
      check("wr_wstrb", AXI_WSTRB, 4'hF);
      check("wr_awcache", AXI_AWCACHE, 4'b0011);
      check("wr_cmd_ready_busy", CMD_READY, 1'b0);
      check("wr_bready_c1", AXI_BREADY, 1'b0);
      tick();
      check("wr_awvalid_c2", AXI_AWVALID, 1'b0);
      check("wr_wvalid_c2", AXI_WVALID, 1'b0);
      check("wr_awaddr_idle", AXI_AWADDR, 32'h0);
      check("wr_awcache_idle", AXI_AWCACHE, 4'b0000);
      check("wr_bready_c2", AXI_BREADY, 1'b1);
      AXI_BVALID = 1'b1; AXI_BRESP = 2'b00;
      tick();
      AXI_BVALID = 1'b0;
      check("wr_rsp_valid_c3", RSP_VALID, 1'b1);
      check("wr_rsp_resp", RSP_RESP, 2'b00);
      check("wr_rsp_write", RSP_WRITE, 1'b1);
      check("wr_rsp_timeout", RSP_TIMEOUT, 1'b0);
      check("wr_bready_c3", AXI_BREADY, 1'b0);
      tick();
      check("wr_rsp_valid_done", RSP_VALID, 1'b0);
      check("wr_cmd_ready_back", CMD_READY, 1'b1);

      // Skewed AW/W: AWREADY held off for three cycles
      AXI_AWREADY = 1'b0; AXI_WREADY = 1'b1;
      send(1'b1, 32'h0000_0020, 32'h1122_3344, 4'h3);
      check("sk_awvalid_c1", AXI_AWVALID, 1'b1);
      check("sk_wvalid_c1", AXI_WVALID, 1'b1);
      tick();
      check("sk_wvalid_c2", AXI_WVALID, 1'b0);
      check("sk_awvalid_c2", AXI_AWVALID, 1'b1);
      check("sk_bready_c2", AXI_BREADY, 1'b0);
      tick();
      check("sk_awvalid_c3", AXI_AWVALID, 1'b1);
      check("sk_bready_c3", AXI_BREADY, 1'b0);
      tick();
      check("sk_awvalid_c4", AXI_AWVALID, 1'b1);
      check("sk_awaddr_c4", AXI_AWADDR, 32'h20);
      AXI_AWREADY = 1'b1;
      tick();
      AXI_AWREADY = 1'b0;
      check("sk_awvalid_c5", AXI_AWVALID, 1'b0);
      check("sk_bready_c5", AXI_BREADY, 1'b1);
      AXI_BVALID = 1'b1;
      tick();
      AXI_BVALID = 1'b0;
      check("sk_rsp_valid", RSP_VALID, 1'b1);
      tick();

      // Error response with RSP_READY backpressure
      AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1; RSP_READY = 1'b0;
      send(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
      tick();
      AXI_BVALID = 1'b1; AXI_BRESP = 2'b10;
      tick();
      AXI_BVALID = 1'b0; AXI_BRESP = 2'b00;
      for (int i = 0; i < 10; i++) begin
         check("bp_rsp_valid", RSP_VALID, 1'b1);
         check("bp_rsp_resp", RSP_RESP, 2'b10);
         check("bp_cmd_ready", CMD_READY, 1'b0);
         tick();
      end
      RSP_READY = 1'b1;
      tick();
      check("bp_rsp_taken", RSP_VALID, 1'b0);
      check("bp_cmd_ready_back", CMD_READY, 1'b1);

      // Read with delayed ARREADY and a five-cycle data delay
      AXI_AWREADY = 1'b0; AXI_WREADY = 1'b0;
      send(1'b0, 32'h0000_0004, 32'h0, 4'h0);
      check("rd_arvalid_c1", AXI_ARVALID, 1'b1);
      check("rd_araddr", AXI_ARADDR, 32'h4);
      check("rd_arcache", AXI_ARCACHE, 4'b0011);
      check("rd_awvalid", AXI_AWVALID, 1'b0);
      tick();
      check("rd_arvalid_c2", AXI_ARVALID, 1'b1);
      AXI_ARREADY = 1'b1;
      tick();
      AXI_ARREADY = 1'b0;
      check("rd_arvalid_c3", AXI_ARVALID, 1'b0);
      check("rd_araddr_idle", AXI_ARADDR, 32'h0);
      check("rd_rready_c3", AXI_RREADY, 1'b1);
      repeat (4) tick();
      check("rd_rready_wait", AXI_RREADY, 1'b1);
      check("rd_rsp_early", RSP_VALID, 1'b0);
      AXI_RVALID = 1'b1; AXI_RDATA = 32'h1234_5678; AXI_RRESP = 2'b00;
      tick();
      AXI_RVALID = 1'b0; AXI_RDATA = 32'h0;
      check("rd_rsp_valid", RSP_VALID, 1'b1);
      check("rd_rsp_rdata", RSP_RDATA, 32'h1234_5678);
      check("rd_rsp_resp", RSP_RESP, 2'b00);
      check("rd_rsp_write", RSP_WRITE, 1'b0);
      check("rd_rready_done", AXI_RREADY, 1'b0);
      tick();

      // Timeout: ARREADY never arrives
      send(1'b0, 32'h0000_0008, 32'h0, 4'h0);
      n = 0;
      while (AXI_ARVALID && n < 40) begin
         n++;
         tick();
      end
      check("to_arvalid_cycles", n, 16);
      check("to_arvalid_low", AXI_ARVALID, 1'b0);
      check("to_rsp_valid", RSP_VALID, 1'b1);
      check("to_rsp_timeout", RSP_TIMEOUT, 1'b1);
      check("to_rsp_resp", RSP_RESP, 2'b10);
      check("to_rsp_rdata", RSP_RDATA, 32'h0);
      check("to_rready", AXI_RREADY, 1'b0);
      tick();
      check("to_cmd_ready", CMD_READY, 1'b1);

      // Next read proceeds; RVALID already high on entry to the data phase
      AXI_ARREADY = 1'b1; AXI_RVALID = 1'b1; AXI_RDATA = 32'hA5A5_0F0F; AXI_RRESP = 2'b01;
      send(1'b0, 32'h0000_000C, 32'h0, 4'h0);
      check("nx_arvalid_c1", AXI_ARVALID, 1'b1);
      tick();
      check("nx_rready_c2", AXI_RREADY, 1'b1);
      tick();
      AXI_ARREADY = 1'b0; AXI_RVALID = 1'b0; AXI_RDATA = 32'h0; AXI_RRESP = 2'b00;
      check("nx_rsp_valid", RSP_VALID, 1'b1);
      check("nx_rsp_rdata", RSP_RDATA, 32'hA5A5_0F0F);
      check("nx_rsp_resp", RSP_RESP, 2'b01);
      check("nx_rsp_timeout", RSP_TIMEOUT, 1'b0);
      tick();

      // Reset while waiting for B
      AXI_AWREADY = 1'b1; AXI_WREADY = 1'b1;
      send(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF);
      tick();
      check("mr_bready", AXI_BREADY, 1'b1);
      ARESET = 1'b1;
      tick();
      check("mr_bready_rst", AXI_BREADY, 1'b0);
      check("mr_cmd_ready_rst", CMD_READY, 1'b0);
      check("mr_rsp_valid_rst", RSP_VALID, 1'b0);
      check("mr_rsp_write_rst", RSP_WRITE, 1'b0);
      ARESET = 1'b0;
      tick();
      check("mr_cmd_ready_rel", CMD_READY, 1'b1);
      check("mr_rsp_valid_rel", RSP_VALID, 1'b0);

      // DATA_WIDTH = 64 write with partial strobes
      check("w64_cmd_ready", w64_cmd_ready, 1'b1);
      w64_cmd_valid = 1'b1; w64_cmd_write = 1'b1; w64_cmd_addr = 32'h0000_0010;
      w64_cmd_wdata = 64'h0123_4567_DEAD_BEEF; w64_cmd_wstrb = 8'h0F;
      tick();
      w64_cmd_valid = 1'b0;
      check("w64_awvalid", w64_awvalid, 1'b1);
      check("w64_awaddr", w64_awaddr, 32'h10);
      check("w64_wdata", w64_wdata, 64'h0123_4567_DEAD_BEEF);
      check("w64_wstrb", w64_wstrb, 8'h0F);
      tick();
      check("w64_bready", w64_bready, 1'b1);
      w64_bvalid = 1'b1;
      tick();
      w64_bvalid = 1'b0;
      check("w64_rsp_valid", w64_rsp_valid, 1'b1);
      check("w64_rsp_write", w64_rsp_write, 1'b1);
      check("w64_rsp_resp", w64_rsp_resp, 2'b00);
      check("w64_rsp_rdata", w64_rsp_rdata, 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axilm_cmd_master.md
# axilm_cmd_master

Synthesizable, parametrised AXI4-Lite master that turns single-beat read/write commands from a valid/ready command port into AXI4-Lite transactions and returns the data and response on a valid/ready response port. Write address and write data are issued concurrently and retire independently. A per-transaction timeout reports hung slaves. It drives the register space of the JPEG decoder and its peripherals from internal control logic, replacing simulation-only bus tasks.

## Interface
- ADDR_WIDTH, 32, width of address on command port and AXI AW/AR.
- DATA_WIDTH, 32, data width; only 32 and 64 are legal; strobe width is DATA_WIDTH/8.
- TIMEOUT, 256, cycles a wait state may last before abort; 0 disables the timeout.
- AXCACHE, 4'b0011, value driven on AWCACHE/ARCACHE while the matching VALID is high.

- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- CMD_VALID / CMD_READY  in / out  1 / 1  command handshake.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  ADDR_WIDTH  target address, passed unmodified.
- CMD_WDATA  in  DATA_WIDTH  write data; ignored for reads.
- CMD_WSTRB  in  DATA_WIDTH/8  write strobes; ignored for reads.
- RSP_VALID / RSP_READY  out / in  1 / 1  response handshake.
- RSP_WRITE  out  1  echo of CMD_WRITE.
- RSP_RDATA  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- RSP_RESP  out  2  BRESP/RRESP; 2'b10 on timeout.
- RSP_TIMEOUT  out  1  transaction aborted by the timeout.
- AXI_AWADDR, AXI_AWCACHE, AXI_AWPROT, AXI_AWVALID / AXI_AWREADY  out / in  ADDR_WIDTH, 4, 3, 1 / 1.
- AXI_WDATA, AXI_WSTRB, AXI_WVALID / AXI_WREADY  out / in  DATA_WIDTH, DATA_WIDTH/8, 1 / 1.
- AXI_BVALID, AXI_BRESP / AXI_BREADY  in / out  1, 2 / 1.
- AXI_ARADDR, AXI_ARCACHE, AXI_ARPROT, AXI_ARVALID / AXI_ARREADY  out / in  ADDR_WIDTH, 4, 3, 1 / 1.
- AXI_RDATA, AXI_RRESP, AXI_RVALID / AXI_RREADY  in / out  DATA_WIDTH, 2, 1 / 1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP.
- **IDLE**
  - CMD_READY = 1, and only in IDLE.
  - On CMD_VALID, latch the command and go to WR_REQ or RD_REQ.
- **WR_REQ**
  - AWVALID and WVALID rise together. Each drops on its own handshake (VALID & READY at an edge). The other stays high until its own handshake.
  - Go to WR_RESP once both have completed. They may complete on the same edge.
- **WR_RESP**
  - BREADY = 1.
  - On BVALID, capture BRESP and go to RESP.
- **RD_REQ**
  - ARVALID = 1 until ARREADY, then go to RD_DATA.
- **RD_DATA**
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP and go to RESP.
- **RESP**
  - RSP_VALID = 1; response fields are stable while waiting.
  - On RSP_READY, go to IDLE.
- **Driving rules**
  - AWADDR/ARADDR, WDATA, WSTRB and AXCACHE are driven only while the matching VALID is high; otherwise 0.
  - AWPROT/ARPROT are always 3'b000.
- **Timeout**
  - The counter clears on every state change and counts each cycle spent in WR_REQ, WR_RESP, RD_REQ or RD_DATA.
  - When it reaches TIMEOUT: deassert all AXI VALID/READY outputs, set RSP_TIMEOUT = 1, RSP_RESP = 2'b10, RSP_RDATA = 0, and go to RESP.
  - This abort deliberately breaks AXI protocol. It is a debug recovery path only.
  - Counter width is $clog2(TIMEOUT+1).
- **Invariant:** exactly one transaction is in flight; no new command is accepted until the response has been taken.

## Timing
- Reset state: IDLE with CMD_READY = 1 at the first edge after reset deasserts. While ARESET is asserted, CMD_READY is 0.
- Every other output resets to 0.
- Reset mid-transaction: all VALID/READY outputs drop the next cycle and any pending response is discarded.
- All outputs are registered; no combinational path runs from any input to any output.
- Best-case latency with an always-ready slave that responds one cycle after the handshake:
  - Command accepted at edge 0; AW/W (or AR) VALID high in cycle 1.
  - Handshake at edge 1; B/R handshake at edge 2.
  - RSP_VALID high in cycle 3 → 4 cycles command-to-response.
  - Throughput is 1 transaction per 4 cycles with RSP_READY tied high.
- BVALID or RVALID already high on entry to WR_RESP/RD_DATA completes at the first edge in that state.

## Test plan
- **Write, always-ready slave:** write 0x0000_0010 ← 0xDEAD_BEEF, WSTRB 4'hF → AW and W both in cycle 1, BREADY in cycle 2, RSP_VALID in cycle 3 with RSP_RESP = 0 and RSP_WRITE = 1.
- **Skewed AW/W:** AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID holds 4 cycles, BREADY rises only after both handshakes.
- **Read with delay:** read 0x0000_0004, slave returns 0x1234_5678 with RRESP = 2'b00 after 5 cycles → RSP_RDATA = 0x1234_5678; ARVALID high exactly until the ARREADY edge.
- **Error and backpressure:** BRESP = 2'b10 and RSP_READY held low 10 cycles → RSP_RESP = 2'b10 stable for the 10 cycles, CMD_READY = 0 throughout.
- **Timeout:** TIMEOUT = 16, slave never raises ARREADY → ARVALID drops after 16 cycles, RSP_TIMEOUT = 1, RSP_RESP = 2'b10, RSP_RDATA = 0; the next command proceeds normally.
- **Reset mid-operation and DATA_WIDTH = 64:** ARESET asserted in WR_RESP → all outputs 0 the next cycle, CMD_READY = 1 one cycle after release. Repeat the first write with DATA_WIDTH = 64 and WSTRB 8'h0F → strobes passed unmodified.
